// File: rtl/result_addr_wsel.sv
// result_addr_wsel
// Write-side address generator for the systolic array result path. A single
// start pulse launches a drain; each of the 8 column groups gets its own
// write enable and de-skewed address (0..NUM_WORDS-1), offset by
// DRAIN_LAT + g*GROUP_SKEW cycles. hold freezes all progress.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle drain request (ignored unless idle)
//   hold                  array stall, freezes progress while high
//   busy                  drain in progress
//   done                  one-cycle pulse coincident with the final write
//   sram_wen_a0..a7       per-group write enable
//   sram_waddr_a0..a7     per-group 10-bit write address
module result_addr_wsel #(
    parameter int DRAIN_LAT  = 32,
    parameter int GROUP_SKEW = 4,
    parameter int NUM_WORDS  = 99,
    parameter int IDLE_ADDR  = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    output logic       busy,
    output logic       done,
    output logic       sram_wen_a0,
    output logic       sram_wen_a1,
    output logic       sram_wen_a2,
    output logic       sram_wen_a3,
    output logic       sram_wen_a4,
    output logic       sram_wen_a5,
    output logic       sram_wen_a6,
    output logic       sram_wen_a7,
    output logic [9:0] sram_waddr_a0,
    output logic [9:0] sram_waddr_a1,
    output logic [9:0] sram_waddr_a2,
    output logic [9:0] sram_waddr_a3,
    output logic [9:0] sram_waddr_a4,
    output logic [9:0] sram_waddr_a5,
    output logic [9:0] sram_waddr_a6,
    output logic [9:0] sram_waddr_a7
);

    localparam int          NUM_GROUPS = 8;
    localparam int          END_CNT    = DRAIN_LAT + (NUM_GROUPS-1)*GROUP_SKEW + NUM_WORDS - 1;
    localparam logic [7:0]  END_CNT8   = 8'(END_CNT);
    localparam logic [9:0]  IDLE_A10   = 10'(IDLE_ADDR);
    localparam logic signed [10:0] LAST_OFF = 11'(NUM_WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                            state_q, state_d;
    logic [7:0]                        cnt_q, cnt_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic [NUM_GROUPS-1:0]             wen_q, wen_d;
    logic [NUM_GROUPS-1:0][9:0]        waddr_q, waddr_d;
    logic [NUM_GROUPS-1:0]             in_win;
    logic signed [NUM_GROUPS-1:0][10:0] off;

    // Per-group offset into its own write window; signed so that groups
    // still waiting on their skew see a negative value.
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_off
        localparam logic signed [10:0] GRP_OFS = 11'(DRAIN_LAT + g*GROUP_SKEW);
        assign off[g]    = $signed({3'b000, cnt_q}) - GRP_OFS;
        assign in_win[g] = (off[g] >= 0) && (off[g] <= LAST_OFF);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: if (!hold) begin
                if (cnt_q == END_CNT8) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // busy lives in the output stage (one cycle behind cnt), so it stays
        // high through the done cycle and drops on the edge after it.
        busy_d = (state_q == RUN);
    end

    always_comb begin
        wen_d   = '0;
        waddr_d = waddr_q;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            // A stall in RUN freezes addresses so nothing is skipped or repeated.
            if (!(state_q == RUN && hold)) begin
                if (state_q == RUN && in_win[g]) begin
                    wen_d[g]   = 1'b1;
                    waddr_d[g] = off[g][9:0];
                end else begin
                    waddr_d[g] = IDLE_A10;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wen_q   <= '0;
            waddr_q <= {NUM_GROUPS{IDLE_A10}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign sram_wen_a0   = wen_q[0];
    assign sram_wen_a1   = wen_q[1];
    assign sram_wen_a2   = wen_q[2];
    assign sram_wen_a3   = wen_q[3];
    assign sram_wen_a4   = wen_q[4];
    assign sram_wen_a5   = wen_q[5];
    assign sram_wen_a6   = wen_q[6];
    assign sram_wen_a7   = wen_q[7];
    assign sram_waddr_a0 = waddr_q[0];
    assign sram_waddr_a1 = waddr_q[1];
    assign sram_waddr_a2 = waddr_q[2];
    assign sram_waddr_a3 = waddr_q[3];
    assign sram_waddr_a4 = waddr_q[4];
    assign sram_waddr_a5 = waddr_q[5];
    assign sram_waddr_a6 = waddr_q[6];
    assign sram_waddr_a7 = waddr_q[7];

endmodule
